cory_unloop2d: RTL

- Inverse of the 2-D loop expander: consumes a raster stream marked with row-end (last_x) and frame-end (last_y) flags.
- Passes the data through with regenerated beat/row indices.
- At each frame end, emits a command descriptor (width, height, error) in the same "1 for 1" encoding that the loop expander accepts.
- Used on the return path to recover frame geometry and to check that every row of a frame has the same width.

---
 rtl/cory_unloop2d_pkg.sv | 9 +
 rtl/cory_unloop2d_if.sv | 36 +++
 rtl/cory_unloop.sv | 27 ++
 rtl/cory_unloop2d.sv | 93 +++++++++
 4 files changed

// File: rtl/cory_unloop2d_pkg.sv
// Shared definitions for the 2-D raster unloop block: frame-control state encoding.
package cory_unloop2d_pkg;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_REST  = 1'b1
  } state_t;

endpackage

// File: rtl/cory_unloop2d_if.sv
// Raster beat streams (in/out) plus the frame descriptor channel of cory_unloop2d.
interface cory_unloop2d_if #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int H = 8
);
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic         i_a_last_x;
  logic         i_a_last_y;
  logic         o_a_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic [W-1:0] o_z_cnt_x;
  logic [H-1:0] o_z_cnt_y;
  logic         o_z_last_x;
  logic         o_z_last_y;
  logic         i_z_r;
  logic         o_cmd_v;
  logic [W-1:0] o_cmd_width;
  logic [H-1:0] o_cmd_height;
  logic         o_cmd_err;
  logic         i_cmd_r;

  modport slave (
    input  i_a_v, i_a_d, i_a_last_x, i_a_last_y, i_z_r, i_cmd_r,
    output o_a_r, o_z_v, o_z_d, o_z_cnt_x, o_z_cnt_y, o_z_last_x, o_z_last_y,
    output o_cmd_v, o_cmd_width, o_cmd_height, o_cmd_err
  );

  modport master (
    output i_a_v, i_a_d, i_a_last_x, i_a_last_y, i_z_r, i_cmd_r,
    input  o_a_r, o_z_v, o_z_d, o_z_cnt_x, o_z_cnt_y, o_z_last_x, o_z_last_y,
    input  o_cmd_v, o_cmd_width, o_cmd_height, o_cmd_err
  );
endinterface

// File: rtl/cory_unloop.sv
// 1-D beat counter: index within the current run, saturating run length, and full flag.
module cory_unloop #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beat,
  input  logic         last,
  output logic [W-1:0] cnt,
  output logic [W-1:0] len,
  output logic         full
);

  // full marks both a held (overflowed) index and an unrepresentable length
  assign full = (cnt == '1);
  assign len  = full ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (beat) begin
      if (last)       cnt <= '0;
      else if (!full) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cory_unloop2d.sv
// Raster-to-descriptor unloop: passes beats through with row/beat indices and emits
// one (width, height, err) descriptor per frame, checking that all rows match row 0.
module cory_unloop2d
  import cory_unloop2d_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic          clk,
  input  logic          reset,
  cory_unloop2d_if.slave bus
);

  logic [N-1:0] data;
  logic         last_x, stall, acc, row_acc, frame_acc, err_beat;
  logic [W-1:0] x_cnt, x_len, width_r, frame_w;
  logic [H-1:0] y_cnt, y_len;
  logic         x_full, y_full;
  state_t       state, state_nx;
  logic         cmd_v, cmd_err, err_acc;
  logic [W-1:0] cmd_width;
  logic [H-1:0] cmd_height;

  // Only a frame-ending beat waits for the previous descriptor to drain
  assign last_x    = bus.i_a_last_x | bus.i_a_last_y;
  assign stall     = bus.i_a_last_y & cmd_v & ~bus.i_cmd_r;
  assign acc       = bus.i_a_v & bus.i_z_r & ~stall;
  assign row_acc   = acc & last_x;
  assign frame_acc = acc & bus.i_a_last_y;

  assign data           = bus.i_a_d;
  assign bus.o_z_d      = data;
  assign bus.o_z_v      = bus.i_a_v & ~stall;
  assign bus.o_a_r      = bus.i_z_r & ~stall;
  assign bus.o_z_last_x = last_x;
  assign bus.o_z_last_y = bus.i_a_last_y;
  assign bus.o_z_cnt_x  = x_cnt;
  assign bus.o_z_cnt_y  = y_cnt;

  cory_unloop #(.W(W)) u_x (
    .clk(clk), .reset(reset), .beat(acc), .last(last_x),
    .cnt(x_cnt), .len(x_len), .full(x_full)
  );

  cory_unloop #(.W(H)) u_y (
    .clk(clk), .reset(reset), .beat(row_acc), .last(bus.i_a_last_y),
    .cnt(y_cnt), .len(y_len), .full(y_full)
  );

  // x_full covers both a held index and a saturated row length; y_full likewise for rows
  assign err_beat = (acc & x_full) | (row_acc & y_full) |
                    (row_acc & (state == S_REST) & (x_len != width_r));
  assign frame_w  = (state == S_FIRST) ? x_len : width_r;

  always_comb begin
    state_nx = state;
    if (row_acc) state_nx = bus.i_a_last_y ? S_FIRST : S_REST;
  end

  always_ff @(posedge clk) begin
    if (row_acc && state == S_FIRST) width_r <= x_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FIRST;
      cmd_v      <= 1'b0;
      cmd_width  <= '0;
      cmd_height <= '0;
      cmd_err    <= 1'b0;
      err_acc    <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame_acc) begin
        cmd_v      <= 1'b1;
        cmd_width  <= frame_w;
        cmd_height <= y_len;
        cmd_err    <= err_acc | err_beat;
        err_acc    <= 1'b0;
      end else begin
        if (bus.i_cmd_r) cmd_v <= 1'b0;
        if (err_beat)    err_acc <= 1'b1;
      end
    end
  end

  assign bus.o_cmd_v      = cmd_v;
  assign bus.o_cmd_width  = cmd_width;
  assign bus.o_cmd_height = cmd_height;
  assign bus.o_cmd_err    = cmd_err;

endmodule
